// File: rtl/mips_execute_unit_pkg.sv
// Shared constants for the MIPS execute stage: ALUOp codes, R-type funct
// codes and the 4-bit ALU control enumeration.
package mips_execute_unit_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;
  localparam logic [2:0] ALUOP_XOR   = 3'b111;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_LUI  = 4'b1010,
    ALU_NOR  = 4'b1100
  } alu_ctrl_e;

endpackage

// File: rtl/mips_execute_unit_adder32.sv
// Plain 32-bit wrapping adder; the carry-out is intentionally dropped.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mips_execute_unit.sv
// MIPS execute stage: ALU control decode, 32-bit ALU, PC+4 and branch target,
// all captured in one output register stage.
module mips_execute_unit
  import mips_execute_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [2:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] pc,
  input  logic [31:0] branch_imm,
  output logic        out_valid,
  output logic [3:0]  alu_control,
  output logic        jr,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] pc_plus_4,
  output logic [31:0] branch_target
);

  alu_ctrl_e   ctrl;
  logic        jr_c;
  logic [31:0] result_c;
  logic [31:0] pc_plus_4_c;
  logic [31:0] branch_target_c;
  logic [31:0] branch_off;

  logic        out_valid_d,     out_valid_q;
  logic [3:0]  alu_control_d,   alu_control_q;
  logic        jr_d,            jr_q;
  logic [31:0] alu_result_d,    alu_result_q;
  logic        zero_d,          zero_q;
  logic [31:0] pc_plus_4_d,     pc_plus_4_q;
  logic [31:0] branch_target_d, branch_target_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    ctrl = ALU_ADD;
    jr_c = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_AND: ctrl = ALU_AND;
      ALUOP_OR:  ctrl = ALU_OR;
      ALUOP_SLT: ctrl = ALU_SLT;
      ALUOP_LUI: ctrl = ALU_LUI;
      ALUOP_XOR: ctrl = ALU_XOR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl = ALU_SUB;
          FUNCT_AND:             ctrl = ALU_AND;
          FUNCT_OR:              ctrl = ALU_OR;
          FUNCT_XOR:             ctrl = ALU_XOR;
          FUNCT_NOR:             ctrl = ALU_NOR;
          FUNCT_SLT:             ctrl = ALU_SLT;
          FUNCT_SLTU:            ctrl = ALU_SLTU;
          FUNCT_SLL:             ctrl = ALU_SLL;
          FUNCT_SRL:             ctrl = ALU_SRL;
          FUNCT_SRA:             ctrl = ALU_SRA;
          FUNCT_JR: begin
            ctrl = ALU_ADD;
            jr_c = 1'b1;
          end
          default:               ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  // Shifts operate on src_b (the rt operand), matching MIPS sll/srl/sra.
  always_comb begin
    result_c = 32'h0;
    case (ctrl)
      ALU_AND:  result_c = src_a & src_b;
      ALU_OR:   result_c = src_a | src_b;
      ALU_ADD:  result_c = src_a + src_b;
      ALU_XOR:  result_c = src_a ^ src_b;
      ALU_SLL:  result_c = src_b << shamt;
      ALU_SRL:  result_c = src_b >> shamt;
      ALU_SUB:  result_c = src_a - src_b;
      ALU_SLT:  result_c = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      ALU_SRA:  result_c = $signed(src_b) >>> shamt;
      ALU_SLTU: result_c = (src_a < src_b) ? 32'd1 : 32'd0;
      ALU_LUI:  result_c = {src_b[15:0], 16'h0};
      ALU_NOR:  result_c = ~(src_a | src_b);
      default:  result_c = 32'h0;
    endcase
  end

  assign branch_off = branch_imm << 2;

  adder32 u_pc_adder (
    .a   (pc),
    .b   (32'd4),
    .sum (pc_plus_4_c)
  );

  adder32 u_branch_adder (
    .a   (pc_plus_4_c),
    .b   (branch_off),
    .sum (branch_target_c)
  );

  // Results hold when no valid input arrives; only out_valid tracks in_valid.
  always_comb begin
    out_valid_d     = in_valid;
    alu_control_d   = alu_control_q;
    jr_d            = jr_q;
    alu_result_d    = alu_result_q;
    zero_d          = zero_q;
    pc_plus_4_d     = pc_plus_4_q;
    branch_target_d = branch_target_q;
    if (in_valid) begin
      alu_control_d   = ctrl;
      jr_d            = jr_c;
      alu_result_d    = result_c;
      zero_d          = (result_c == 32'h0);
      pc_plus_4_d     = pc_plus_4_c;
      branch_target_d = branch_target_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      alu_control_q   <= 4'h0;
      jr_q            <= 1'b0;
      alu_result_q    <= 32'h0;
      zero_q          <= 1'b0;
      pc_plus_4_q     <= 32'h0;
      branch_target_q <= 32'h0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_control_q   <= alu_control_d;
      jr_q            <= jr_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      pc_plus_4_q     <= pc_plus_4_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_control   = alu_control_q;
  assign jr            = jr_q;
  assign alu_result    = alu_result_q;
  assign zero          = zero_q;
  assign pc_plus_4     = pc_plus_4_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_mips_execute_unit.sv
// Self-checking bench for mips_execute_unit: directed cases plus randomized
// traffic compared against a behavioural model of the execute stage.
`timescale 1ns/1ps
module tb_mips_execute_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a, src_b, pc, branch_imm;
  logic        out_valid;
  logic [3:0]  alu_control;
  logic        jr;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_plus_4, branch_target;

  int tests = 0;
  int fails = 0;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU,
                K_SLL, K_SRL, K_SRA, K_LUI} kind_e;

  typedef struct {
    logic        valid;
    logic [3:0]  ctrl;
    logic        jr;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pc4;
    logic [31:0] bt;
  } exp_t;

  exp_t exp_q;

  mips_execute_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .alu_op        (alu_op),
    .funct         (funct),
    .shamt         (shamt),
    .src_a         (src_a),
    .src_b         (src_b),
    .pc            (pc),
    .branch_imm    (branch_imm),
    .out_valid     (out_valid),
    .alu_control   (alu_control),
    .jr            (jr),
    .alu_result    (alu_result),
    .zero          (zero),
    .pc_plus_4     (pc_plus_4),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  function automatic kind_e kind_of(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'd0: return K_ADD;
      3'd1: return K_SUB;
      3'd3: return K_AND;
      3'd4: return K_OR;
      3'd5: return K_SLT;
      3'd6: return K_LUI;
      3'd7: return K_XOR;
      default: ;
    endcase
    case (fn)
      6'd32, 6'd33: return K_ADD;
      6'd34, 6'd35: return K_SUB;
      6'd36: return K_AND;
      6'd37: return K_OR;
      6'd38: return K_XOR;
      6'd39: return K_NOR;
      6'd42: return K_SLT;
      6'd43: return K_SLTU;
      6'd0:  return K_SLL;
      6'd2:  return K_SRL;
      6'd3:  return K_SRA;
      default: return K_ADD;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input kind_e k);
    case (k)
      K_AND: return 4'd0;   K_OR:   return 4'd1;  K_ADD: return 4'd2;
      K_XOR: return 4'd3;   K_SLL:  return 4'd4;  K_SRL: return 4'd5;
      K_SUB: return 4'd6;   K_SLT:  return 4'd7;  K_SRA: return 4'd8;
      K_SLTU: return 4'd9;  K_LUI:  return 4'd10; default: return 4'd12;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] p,
                                 input logic [31:0] imm);
    exp_t        e;
    kind_e       k;
    longint      sa, sb;
    logic [63:0] wide;
    k  = kind_of(op, fn);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.valid = 1'b1;
    e.ctrl  = code_of(k);
    e.jr    = (op == 3'd2) && (fn == 6'd8);
    case (k)
      K_ADD:  e.result = 32'(a + b);
      K_SUB:  e.result = 32'(a - b);
      K_AND:  e.result = a & b;
      K_OR:   e.result = a | b;
      K_XOR:  e.result = a ^ b;
      K_NOR:  e.result = ~(a | b);
      K_SLT:  e.result = (sa < sb) ? 32'd1 : 32'd0;
      K_SLTU: e.result = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
      K_SLL:  e.result = 32'(b * (32'd1 << sh));
      K_SRL:  e.result = b / (32'd1 << sh);
      K_SRA: begin
        wide = {{32{b[31]}}, b} >> sh;
        e.result = wide[31:0];
      end
      default: e.result = 32'(b * 32'd65536);
    endcase
    e.zero = (e.result == 32'd0);
    e.pc4  = 32'(p + 32'd4);
    e.bt   = 32'(p + 32'd4 + imm * 32'd4);
    return e;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid),   32'(exp_q.valid));
    check({tag, ".ctrl"},  32'(alu_control), 32'(exp_q.ctrl));
    check({tag, ".jr"},    32'(jr),          32'(exp_q.jr));
    check({tag, ".res"},   alu_result,       exp_q.result);
    check({tag, ".zero"},  32'(zero),        32'(exp_q.zero));
    check({tag, ".pc4"},   pc_plus_4,        exp_q.pc4);
    check({tag, ".bt"},    branch_target,    exp_q.bt);
  endtask

  task automatic reset_exp();
    exp_q = '{valid: 1'b0, ctrl: 4'h0, jr: 1'b0, result: 32'h0, zero: 1'b0,
              pc4: 32'h0, bt: 32'h0};
  endtask

  // Drive one input set at the falling edge, clock it in, update the model
  // and compare every output one step after the rising edge.
  task automatic step(input string tag, input logic v, input logic [2:0] op,
                      input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] imm);
    @(negedge clk);
    in_valid = v; alu_op = op; funct = fn; shamt = sh;
    src_a = a; src_b = b; pc = p; branch_imm = imm;
    @(posedge clk);
    #1;
    if (v) exp_q = model(op, fn, sh, a, b, p, imm);
    else   exp_q.valid = 1'b0;
    compare_all(tag);
  endtask

  logic [5:0] funct_pool [14] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
                                  6'd38, 6'd39, 6'd42, 6'd43, 6'd0, 6'd2,
                                  6'd3, 6'd8};

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    reset_exp();
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 3'd0; funct = 6'd0; shamt = 5'd0;
    src_a = 32'h0; src_b = 32'h0; pc = 32'h0; branch_imm = 32'h0;
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("sub", 1'b1, 3'b010, 6'b100010, 5'd0, 32'd5, 32'd7, 32'h100, 32'd3);
    check("sub.res_const",  alu_result, 32'hFFFF_FFFE);
    check("sub.ctrl_const", 32'(alu_control), 32'd6);
    step("beq", 1'b1, 3'b001, 6'd0, 5'd0, 32'h1234, 32'h1234, 32'h200, 32'd0);
    check("beq.zero_const", 32'(zero), 32'd1);
    step("slt", 1'b1, 3'b101, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0);
    check("slt.res_const", alu_result, 32'd1);
    step("sra", 1'b1, 3'b010, 6'b000011, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'd0);
    check("sra.res_const", alu_result, 32'hF800_0000);
    step("srl", 1'b1, 3'b010, 6'b000010, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'd0);
    check("srl.res_const", alu_result, 32'h0800_0000);
    step("jr", 1'b1, 3'b010, 6'b001000, 5'd0, 32'h0040_1000, 32'h0, 32'h0, 32'd0);
    check("jr.jr_const",   32'(jr), 32'd1);
    check("jr.ctrl_const", 32'(alu_control), 32'd2);
    step("bwd", 1'b1, 3'b000, 6'd0, 5'd0, 32'd1, 32'd2, 32'h0040_0000, 32'hFFFF_FFFF);
    check("bwd.pc4_const", pc_plus_4, 32'h0040_0004);
    check("bwd.bt_const",  branch_target, 32'h0040_0000);
    step("pcwrap", 1'b1, 3'b011, 6'd0, 5'd0, 32'hF0F0, 32'hFF00, 32'hFFFF_FFFC, 32'd5);
    check("pcwrap.pc4_const", pc_plus_4, 32'h0);
    step("unkfn", 1'b1, 3'b010, 6'b111111, 5'd0, 32'd10, 32'd20, 32'h4, 32'd0);
    check("unkfn.ctrl_const", 32'(alu_control), 32'd2);
    check("unkfn.jr_const",   32'(jr), 32'd0);
    step("lui", 1'b1, 3'b110, 6'd0, 5'd0, 32'h0, 32'hABCD_1234, 32'h0, 32'd0);

    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 3'b001, 6'd0, 5'd0, 32'h5, 32'h6, 32'h8, 32'd1);
    check("hold.res_const", alu_result, 32'h1234_0000);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rf = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 13)];
      step("rand", ($urandom_range(0, 3) != 0), 3'($urandom), rf, 5'($urandom),
           ra, rb, $urandom, $urandom);
    end

    step("pre_rst", 1'b1, 3'b111, 6'd0, 5'd0, 32'h0F0F, 32'h00FF, 32'h1000, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    reset_exp();
    compare_all("midrst");
    #1 rst_n = 1'b1;
    step("post_rst", 1'b1, 3'b100, 6'd0, 5'd0, 32'h00F0, 32'h0F00, 32'h2000, 32'd2);
    check("post_rst.res_const", alu_result, 32'h0FF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
